seg7_dec_display: RTL and testbench
===================================

// Module: seg7_dec_display
// PURPOSE
//  Downstream of the UART byte register: takes the held 8-bit received value and shows it
//  as a 3-digit decimal number (0..255) on a multiplexed 7-segment display (3 common lines).
//  Sequential binary-to-BCD conversion (shift-add-3), leading-zero blanking and digit scan.
// PARAMETERS
//  DIGIT_CYCLES   12000  clk cycles each digit is lit per scan slot (min 2)
//  SEG_ACTIVE_LOW 1      1: seg bit 0 = segment on; 0: bit 1 = on
//  CA_ACTIVE_LOW  1      1: ca bit 0 = digit enabled; 0: bit 1 = enabled
//  LZ_BLANK       1      1: blank leading zeros; 0: always show 3 digits
// PORTS
//  clk     in   1   system clock
//  rst     in   1   reset, synchronous, active-low
//  binary  in   8   value to display, may change on any cycle
//  seg     out  7   {g,f,e,d,c,b,a}, registered, polarity per SEG_ACTIVE_LOW
//  ca      out  3   digit enables, ca[0]=ones, ca[1]=tens, ca[2]=hundreds, registered
//  bcd     out  12  {hundreds,tens,ones} currently displayed, registered
//  busy    out  1   1 while conversion FSM is not IDLE
// BEHAVIOUR
//  Reset (rst=0 at a clk edge): FSM=IDLE, valid flag cleared, bcd=12'h000, busy=0,
//   scan counter=0, digit index=0, seg=all segments off, ca=all digits off.
//  Conversion FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: if valid flag clear or binary != last_val: capture binary into shift reg, clear
//    BCD accumulator, last_val<=binary, go SHIFT (load cycle = C0). Else stay.
//   SHIFT: 8 iterations, one per cycle (C1..C8); per iteration each BCD nibble >=5 gets +3,
//    then {bcd_acc,shift} shifts left 1. After 8th go DONE.
//   DONE (C9): bcd<=bcd_acc, valid flag set, go IDLE. bcd visible at C10.
//   busy=1 from cycle after C0 through DONE; fixed latency 10 cycles from change detect.
//   binary changes during SHIFT/DONE are ignored; re-compared on return to IDLE, so the
//    final stable value is always converted (worst case 20 cycles after it settles).
//   bcd updates atomically; never shows a partially converted value.
//   Widths: accumulator 12 bits, no overflow for 0..255; hundreds nibble max 2.
//  Scan: counter 0..DIGIT_CYCLES-1, wraps to 0; on wrap digit index 0->1->2->0.
//   seg/ca registered from (index, bcd): one-cycle pipeline; exactly one ca active after
//    first post-reset cycle.
//  Blanking (LZ_BLANK=1): hundreds blank if 0; tens blank if hundreds==0 and tens==0;
//   ones never blank. Blank digit: ca still active, all segments off.
//  Encoding (active-high, inverted if SEG_ACTIVE_LOW): 0=3F 1=06 2=5B 3=4F 4=66 5=6D
//   6=7D 7=07 8=7F 9=6F blank=00; nibble >9 (unreachable) -> blank.
//  Reset mid-conversion: aborts, all state to reset values, reconverts current binary.
// TESTING (DIGIT_CYCLES=4, both polarity params=1, LZ_BLANK=1)
//  Reset, binary=0 -> seg=7F, ca=7 during rst; after release bcd=000, ones shows 0 (seg=40).
//  binary 0->255 held -> busy high 9 cycles, bcd=12'h255 exactly 10 cycles after detect.
//  binary=7 -> bcd=007; hundreds/tens slots seg=7F, ones slot seg=78 ("7").
//  Scan order: ca sequence 6,5,3,6,... each value held exactly 4 cycles.
//  binary 100 then 42 on C3 of conversion -> bcd=100 first, then 042 after second pass.
//  rst low during SHIFT with binary=200 -> bcd=000 after reset, then 200 after 10 cycles.

Source files
------------

// File: rtl/seg7_dec_display.sv
// Shows the held 8-bit value as 0..255 on a 3-digit multiplexed 7-segment display.
// A shift-add-3 FSM converts to BCD, and a free-running scan drives one digit at a time.
module seg7_dec_display #(
    parameter int DIGIT_CYCLES   = 12000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int CA_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  binary,
    output logic [6:0]  seg,
    output logic [2:0]  ca,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_CYCLES - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [2:0] CA_OFF  = (CA_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic        valid;
    logic [7:0]  last_val;
    logic [7:0]  shreg;
    logic [11:0] acc;
    logic [2:0]  bit_cnt;
    logic        start;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    pat;
    logic [6:0]    seg_nxt;
    logic [2:0]    ca_nxt;

    function automatic logic [11:0] add3(input logic [11:0] a);
        logic [11:0] r;
        r = a;
        for (int i = 0; i < 3; i++)
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0:    enc = 7'h3F;
            4'd1:    enc = 7'h06;
            4'd2:    enc = 7'h5B;
            4'd3:    enc = 7'h4F;
            4'd4:    enc = 7'h66;
            4'd5:    enc = 7'h6D;
            4'd6:    enc = 7'h7D;
            4'd7:    enc = 7'h07;
            4'd8:    enc = 7'h7F;
            4'd9:    enc = 7'h6F;
            default: enc = 7'h00;
        endcase
    endfunction

    // A never-converted value always starts a pass, so reset reconverts whatever is present.
    assign start = !valid || (binary != last_val);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid    <= 1'b0;
            last_val <= '0;
            shreg    <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            bcd      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    shreg    <= binary;
                    acc      <= '0;
                    last_val <= binary;
                    bit_cnt  <= '0;
                end
                SHIFT: begin
                    {acc, shreg} <= {add3(acc), shreg} << 1;
                    bit_cnt      <= bit_cnt + 3'd1;
                end
                DONE: begin
                    bcd   <= acc;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        nib   = '0;
        blank = 1'b0;
        case (idx)
            2'd0: nib = bcd[3:0];
            2'd1: begin
                nib   = bcd[7:4];
                blank = (LZ_BLANK != 0) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
            end
            2'd2: begin
                nib   = bcd[11:8];
                blank = (LZ_BLANK != 0) && (bcd[11:8] == 4'd0);
            end
            default: blank = 1'b1;
        endcase
        pat     = blank ? 7'h00 : enc(nib);
        seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
        ca_nxt  = (CA_ACTIVE_LOW != 0) ? ~(3'b001 << idx) : (3'b001 << idx);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg <= SEG_OFF;
            ca  <= CA_OFF;
        end else begin
            seg <= seg_nxt;
            ca  <= ca_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_dec_display.sv
// Directed bench for seg7_dec_display: reset, scan order, conversion latency,
// mid-conversion changes, reset abort and a table of displayed values.
module tb_seg7_dec_display;

    logic        clk;
    logic        rst;
    logic [7:0]  binary;
    logic [6:0]  seg;
    logic [2:0]  ca;
    logic [11:0] bcd;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_dec_display #(
        .DIGIT_CYCLES  (4),
        .SEG_ACTIVE_LOW(1),
        .CA_ACTIVE_LOW (1),
        .LZ_BLANK      (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .binary(binary),
        .seg   (seg),
        .ca    (ca),
        .bcd   (bcd),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic [11:0] exp_bcd;
        logic [6:0]  h;
        logic [6:0]  t;
        logic [6:0]  o;
    } vec_t;

    vec_t vecs[10];
    logic [2:0] ca_seq[3];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{8'd7,   12'h007, 7'h7F, 7'h7F, 7'h78};
        vecs[1] = '{8'd42,  12'h042, 7'h7F, 7'h19, 7'h24};
        vecs[2] = '{8'd100, 12'h100, 7'h79, 7'h40, 7'h40};
        vecs[3] = '{8'd255, 12'h255, 7'h24, 7'h12, 7'h12};
        vecs[4] = '{8'd10,  12'h010, 7'h7F, 7'h79, 7'h40};
        vecs[5] = '{8'd9,   12'h009, 7'h7F, 7'h7F, 7'h10};
        vecs[6] = '{8'd205, 12'h205, 7'h24, 7'h40, 7'h12};
        vecs[7] = '{8'd0,   12'h000, 7'h7F, 7'h7F, 7'h40};
        vecs[8] = '{8'd138, 12'h138, 7'h79, 7'h30, 7'h00};
        vecs[9] = '{8'd66,  12'h066, 7'h7F, 7'h02, 7'h02};
        ca_seq[0] = 3'b110;
        ca_seq[1] = 3'b101;
        ca_seq[2] = 3'b011;

        // Reset state
        rst    = 1'b0;
        binary = 8'd0;
        step(3);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_ca", 16'(ca), 16'h7);
        check("rst_bcd", 16'(bcd), 16'h000);
        check("rst_busy", 16'(busy), 16'h0);

        // Release; ones slot first, each digit held 4 cycles in order 6,5,3
        rst = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            check("scan_ca", 16'(ca), 16'(ca_seq[((k - 1) / 4) % 3]));
            if (k == 1) begin
                check("post_rst_seg", 16'(seg), 16'h40);
                check("post_rst_bcd", 16'(bcd), 16'h000);
            end
        end

        // 0 -> 255: busy for 9 cycles, result visible 10 cycles after detect
        binary = 8'd255;
        for (int n = 1; n <= 10; n++) begin
            step(1);
            check("lat_busy", 16'(busy), (n <= 9) ? 16'h1 : 16'h0);
            if (n == 9)  check("lat_bcd_old", 16'(bcd), 16'h000);
            if (n == 10) check("lat_bcd_new", 16'(bcd), 16'h255);
        end
        step(5);

        // 100, then 42 during C3: 100 shown first, 42 after a second pass
        binary = 8'd100;
        for (int n = 1; n <= 20; n++) begin
            step(1);
            if (n == 3)  binary = 8'd42;
            if (n == 9)  check("chg_bcd_c9", 16'(bcd), 16'h255);
            if (n == 10) check("chg_bcd_first", 16'(bcd), 16'h100);
            if (n == 19) check("chg_bcd_hold", 16'(bcd), 16'h100);
            if (n == 20) check("chg_bcd_second", 16'(bcd), 16'h042);
        end
        step(5);

        // Reset during SHIFT aborts, then 200 reconverted
        binary = 8'd200;
        step(3);
        check("abort_busy_pre", 16'(busy), 16'h1);
        rst = 1'b0;
        step(1);
        check("abort_bcd", 16'(bcd), 16'h000);
        check("abort_busy", 16'(busy), 16'h0);
        rst = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step(1);
            if (n == 9)  check("reconv_bcd_old", 16'(bcd), 16'h000);
            if (n == 10) check("reconv_bcd", 16'(bcd), 16'h200);
        end

        // Table of values: BCD and per-slot segment patterns over a full scan
        foreach (vecs[i]) begin
            binary = vecs[i].b;
            step(25);
            check("tbl_bcd", 16'(bcd), 16'(vecs[i].exp_bcd));
            for (int j = 0; j < 12; j++) begin
                step(1);
                case (ca)
                    3'b110:  check("tbl_ones", 16'(seg), 16'(vecs[i].o));
                    3'b101:  check("tbl_tens", 16'(seg), 16'(vecs[i].t));
                    3'b011:  check("tbl_hund", 16'(seg), 16'(vecs[i].h));
                    default: check("tbl_ca_onehot", 16'(ca), 16'h6);
                endcase
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
